// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MINI-MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory ready handshake.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unknown opcode enters an absorbing TRAP state).
module mips_multicycle_ctrl #(
    parameter int OPCODE_W = 6,
    parameter int BR_W     = 4,
    parameter int ALUOP_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                branch_taken,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                jump,
    output logic [BR_W-1:0]     branch,
    output logic [1:0]          reg_dst,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                lui_sel,
    output logic                instr_done,
    output logic                trap
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        K_ILLEGAL, K_ALU, K_LW, K_SW, K_BRANCH, K_J, K_JAL
    } kind_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;

    kind_t               kind;
    logic [ALUOP_W-1:0]  alu_op_dec;
    logic                alu_src_dec;
    logic [BR_W-1:0]     br_dec;

    // Opcode classification of the latched instruction
    always_comb begin
        kind        = K_ILLEGAL;
        alu_op_dec  = '0;
        alu_src_dec = 1'b0;
        br_dec      = '0;
        case (int'(op_q))
            0:  begin kind = K_ALU; end
            8:  begin kind = K_ALU; alu_op_dec = ALUOP_W'(1);  alu_src_dec = 1'b1; end
            9:  begin kind = K_ALU; alu_op_dec = ALUOP_W'(3);  alu_src_dec = 1'b1; end
            10: begin kind = K_ALU; alu_op_dec = ALUOP_W'(14); alu_src_dec = 1'b1; end
            12: begin kind = K_ALU; alu_op_dec = ALUOP_W'(8);  alu_src_dec = 1'b1; end
            13: begin kind = K_ALU; alu_op_dec = ALUOP_W'(9);  alu_src_dec = 1'b1; end
            14: begin kind = K_ALU; alu_op_dec = ALUOP_W'(10); alu_src_dec = 1'b1; end
            15: begin kind = K_ALU; alu_op_dec = ALUOP_W'(1);  alu_src_dec = 1'b1; end
            39: begin kind = K_ALU; alu_op_dec = ALUOP_W'(15); alu_src_dec = 1'b1; end
            35: begin kind = K_LW;  alu_op_dec = ALUOP_W'(1);  alu_src_dec = 1'b1; end
            43: begin kind = K_SW;  alu_op_dec = ALUOP_W'(1);  alu_src_dec = 1'b1; end
            4:  begin kind = K_BRANCH; br_dec = BR_W'(1); end
            5:  begin kind = K_BRANCH; br_dec = BR_W'(2); end
            32: begin kind = K_BRANCH; br_dec = BR_W'(3); end
            33: begin kind = K_BRANCH; br_dec = BR_W'(4); end
            34: begin kind = K_BRANCH; br_dec = BR_W'(5); end
            36: begin kind = K_BRANCH; br_dec = BR_W'(6); end
            37: begin kind = K_BRANCH; br_dec = BR_W'(7); end
            38: begin kind = K_BRANCH; br_dec = BR_W'(8); end
            2:  begin kind = K_J;   end
            3:  begin kind = K_JAL; end
            default: kind = K_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        jump       = 1'b0;
        branch     = '0;
        reg_dst    = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = '0;
        lui_sel    = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    op_d     = opcode;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (kind != K_ILLEGAL) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_d = S_TRAP;
`else
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                alu_op  = alu_op_dec;
                alu_src = alu_src_dec;
                case (kind)
                    K_LW, K_SW: state_d = S_MEM;
                    K_BRANCH: begin
                        branch     = br_dec;
                        pc_write   = branch_taken;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    K_J: begin
                        jump       = 1'b1;
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    K_JAL: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_WB;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                alu_op    = alu_op_dec;
                alu_src   = alu_src_dec;
                mem_read  = (kind == K_LW);
                mem_write = (kind == K_SW);
                if (mem_ready) begin
                    if (kind == K_LW) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                alu_op     = alu_op_dec;
                alu_src    = alu_src_dec;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                reg_dst    = (kind == K_JAL) ? 2'b10 : ((op_q == '0) ? 2'b01 : 2'b00);
                mem_to_reg = (kind == K_LW);
                lui_sel    = (int'(op_q) == 15);
                state_d    = S_FETCH;
            end
            S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
                trap = 1'b1;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
        // Reset forces outputs low combinationally so a request is dropped in the same cycle
        if (rst) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            jump       = 1'b0;
            branch     = '0;
            reg_dst    = 2'b00;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            alu_src    = 1'b0;
            alu_op     = '0;
            lui_sel    = 1'b0;
            instr_done = 1'b0;
            trap       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl; expected per-cycle control words come from an instruction-level model.
// Honours ILLEGAL_OP_TRAP_EN the same way as the design.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, jump;
    logic [3:0] branch;
    logic [1:0] reg_dst;
    logic       reg_write, mem_to_reg, alu_src;
    logic [3:0] alu_op;
    logic       lui_sel, instr_done, trap;

    int checks = 0;
    int errors = 0;

    mips_multicycle_ctrl #(.OPCODE_W(6), .BR_W(4), .ALUOP_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write), .jump(jump),
        .branch(branch), .reg_dst(reg_dst), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
        .lui_sel(lui_sel), .instr_done(instr_done), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mr, mw, iod, irw, pcw, jmp;
        logic [3:0] br;
        logic [1:0] rd;
        logic       rw, m2r, asrc;
        logic [3:0] aop;
        logic       lui, done, trp;
    } ctl_t;

    // rdy/bt: 0 or 1 = forced value, 2 = don't-care (randomised)
    typedef struct {
        int   rdy;
        int   bt;
        logic hs;
        ctl_t exp;
    } step_t;

    ctl_t  act;
    step_t plan[$];

    assign act = {mem_read, mem_write, i_or_d, ir_write, pc_write, jump, branch, reg_dst,
                  reg_write, mem_to_reg, alu_src, alu_op, lui_sel, instr_done, trap};

    int legal_ops [21] = '{0, 8, 9, 10, 12, 13, 14, 15, 39, 35, 43, 4, 5, 32, 33, 34, 36, 37, 38, 2, 3};
    int bad_ops   [7]  = '{1, 6, 7, 11, 16, 40, 63};

    // Instruction classes: 0 illegal, 1 ALU, 2 LW, 3 SW, 4 branch, 5 J, 6 JAL
    function automatic int kind_of(int op);
        case (op)
            0, 8, 9, 10, 12, 13, 14, 15, 39: return 1;
            35: return 2;
            43: return 3;
            4, 5, 32, 33, 34, 36, 37, 38: return 4;
            2: return 5;
            3: return 6;
            default: return 0;
        endcase
    endfunction

    function automatic ctl_t alu_of(int op);
        ctl_t e = '0;
        e.asrc = 1'b1;
        case (op)
            8, 15, 35, 43: e.aop = 4'd1;
            9:  e.aop = 4'd3;
            10: e.aop = 4'd14;
            12: e.aop = 4'd8;
            13: e.aop = 4'd9;
            14: e.aop = 4'd10;
            39: e.aop = 4'd15;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] br_code(int op);
        case (op)
            4: return 4'd1;  5: return 4'd2;  32: return 4'd3; 33: return 4'd4;
            34: return 4'd5; 36: return 4'd6; 37: return 4'd7; 38: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic void add(int rdy, int bt, logic hs, ctl_t e);
        step_t s;
        s.rdy = rdy; s.bt = bt; s.hs = hs; s.exp = e;
        plan.push_back(s);
    endfunction

    // Expand one instruction into its expected per-cycle control words
    function automatic void build(int op, int fw, int mw, int bt);
        ctl_t e;
        int   k = kind_of(op);
        plan.delete();
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mr = 1'b1; add(0, 2, 1'b0, e);
        end
        e = '0; e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; add(1, 2, 1'b1, e);
        if (k == 0) begin
`ifdef ILLEGAL_OP_TRAP_EN
            add(2, 2, 1'b0, '0);
            for (int i = 0; i < 4; i++) begin
                e = '0; e.trp = 1'b1; add(2, 2, 1'b0, e);
            end
`else
            e = '0; e.done = 1'b1; add(2, 2, 1'b0, e);
`endif
            return;
        end
        add(2, 2, 1'b0, '0);
        case (k)
            1: begin
                add(2, 2, 1'b0, alu_of(op));
                e = alu_of(op); e.rw = 1'b1; e.done = 1'b1;
                e.rd = (op == 0) ? 2'b01 : 2'b00; e.lui = (op == 15);
                add(2, 2, 1'b0, e);
            end
            2, 3: begin
                add(2, 2, 1'b0, alu_of(op));
                e = alu_of(op); e.iod = 1'b1;
                if (k == 2) e.mr = 1'b1; else e.mw = 1'b1;
                for (int i = 0; i < mw; i++) add(0, 2, 1'b0, e);
                if (k == 3) e.done = 1'b1;
                add(1, 2, 1'b0, e);
                if (k == 2) begin
                    e = alu_of(op); e.rw = 1'b1; e.done = 1'b1; e.m2r = 1'b1;
                    add(2, 2, 1'b0, e);
                end
            end
            4: begin
                e = '0; e.br = br_code(op); e.pcw = (bt != 0); e.done = 1'b1;
                add(2, bt, 1'b0, e);
            end
            5: begin
                e = '0; e.jmp = 1'b1; e.pcw = 1'b1; e.done = 1'b1;
                add(2, 2, 1'b0, e);
            end
            default: begin
                e = '0; e.jmp = 1'b1; e.pcw = 1'b1; add(2, 2, 1'b0, e);
                e = '0; e.rd = 2'b10; e.rw = 1'b1; e.done = 1'b1; add(2, 2, 1'b0, e);
            end
        endcase
    endfunction

    // Drives a built plan (optionally truncated) and compares every cycle
    task automatic run_plan(string name, int op, int nmax);
        int n = (nmax < 0 || nmax > plan.size()) ? plan.size() : nmax;
        for (int i = 0; i < n; i++) begin
            opcode       = plan[i].hs ? 6'(op) : 6'($urandom_range(0, 63));
            mem_ready    = (plan[i].rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(plan[i].rdy);
            branch_taken = (plan[i].bt == 2) ? 1'($urandom_range(0, 1)) : 1'(plan[i].bt);
            @(negedge clk);
            checks++;
            if (act !== plan[i].exp) begin
                errors++;
                $display("FAIL %s op=%0d cycle=%0d got=%h expected=%h", name, op, i + 1, act, plan[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_instr(string name, int op, int fw, int mw, int bt);
        build(op, fw, mw, bt);
        run_plan(name, op, -1);
`ifdef ILLEGAL_OP_TRAP_EN
        if (kind_of(op) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if (act !== '0) begin
                errors++;
                $display("FAIL %s_trap_reset got=%h expected=%h", name, act, ctl_t'('0));
            end
            @(posedge clk); #1;
            rst = 1'b0;
        end
`endif
    endtask

    task automatic test_reset();
        ctl_t e;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            opcode    = 6'($urandom_range(0, 63));
            @(negedge clk);
            checks++;
            if (act !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle=%0d got=%h expected=%h", i, act, ctl_t'('0));
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        mem_ready = 1'b0;
        e = '0; e.mr = 1'b1;
        @(negedge clk);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL first_fetch got=%h expected=%h", act, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        do_instr("addi", 8, 0, 0, 0);
        do_instr("rtype", 0, 1, 0, 0);
        do_instr("lui", 15, 0, 0, 0);
        do_instr("seq", 39, 2, 0, 0);
    endtask

    task automatic test_load_store();
        do_instr("lw_wait3", 35, 0, 3, 0);
        do_instr("lw", 35, 0, 0, 0);
        do_instr("sw", 43, 0, 0, 0);
        do_instr("sw_wait2", 43, 1, 2, 0);
    endtask

    task automatic test_branch();
        do_instr("bgtu_nt", 38, 0, 0, 0);
        do_instr("bgtu_t", 38, 0, 0, 1);
        do_instr("beq_t", 4, 0, 0, 1);
        do_instr("bleu_nt", 37, 0, 0, 0);
    endtask

    task automatic test_jump();
        do_instr("j", 2, 0, 0, 0);
        do_instr("jal", 3, 0, 0, 0);
    endtask

    task automatic test_illegal();
        do_instr("illegal63", 63, 0, 0, 0);
        do_instr("after_illegal", 9, 0, 0, 0);
    endtask

    task automatic test_reset_mid_mem();
        build(35, 0, 5, 0);
        run_plan("lw_abort", 35, 4);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_mid_mem got=%h expected=%h", act, ctl_t'('0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_instr("after_abort", 13, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int op;
        for (int n = 0; n < 40; n++) begin
`ifdef ILLEGAL_OP_TRAP_EN
            op = legal_ops[$urandom_range(0, 20)];
`else
            op = ($urandom_range(0, 7) == 0) ? bad_ops[$urandom_range(0, 6)] : legal_ops[$urandom_range(0, 20)];
`endif
            do_instr("random", op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        // test_reset leaves FETCH waiting; finish that fetch as a NOP-free ADDIU
        do_instr("post_reset", 9, 0, 0, 0);
        test_alu();
        test_load_store();
        test_branch();
        test_jump();
        test_reset_mid_mem();
        test_back_to_back();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
